// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and
// stream framing constants.
package loader_pkg;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_FILL = 3'd4,
    ST_HOLD = 3'd5,
    ST_DONE = 3'd6,
    ST_ERR  = 3'd7
  } loader_state_e;

  // Header length in bytes: a 16-bit little-endian word count.
  localparam int HDR_BYTES  = 2;

  // Bytes per instruction word.
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a byte stream into 32-bit little-endian words. The first byte of a
// word lands in bits 7:0. word_valid is high in the cycle the final byte of
// a word is accepted, with word already holding the complete value, so the
// parent can register the memory write on that same edge.
module byte_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int CW = $clog2(WORD_BYTES);
  localparam int SW = 8 * (WORD_BYTES - 1);

  logic [CW-1:0] cnt_q;
  logic [SW-1:0] sr_q;

  // The last byte completes the word without being stored.
  assign word_valid = byte_valid && (cnt_q == CW'(WORD_BYTES - 1));
  assign word       = {byte_data, sr_q};

  // Byte counter and right-shifting holder for the first three bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (byte_valid) begin
      cnt_q <= word_valid ? '0 : cnt_q + 1'b1;
      sr_q  <= {byte_data, sr_q[SW-1:8]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: reads a length-prefixed little-endian word stream into
// instruction memory, zero-fills the rest of the memory, then releases the
// CPU reset after a short hold. All outputs are registered; the output
// registers are loaded from values derived from the next state, so they
// change on the same edge as the state.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both high; byte_ready_o depends only on loader state and
// never on byte_valid_i.
module prog_loader
  import loader_pkg::*;
#(
  parameter int IM_WORDS    = 32,
  parameter int HOLD_CYCLES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_data_i,
  output logic          byte_ready_o,
  output logic          im_we_o,
  output logic [31:0]   im_addr_o,
  output logic [31:0]   im_wdata_o,
  output logic          cpu_rst_n_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output loader_state_e state_o
);

  // idx carries one extra bit so that N = IM_WORDS fits.
  localparam int IW = $clog2(IM_WORDS) + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1) + 1;

  loader_state_e state_q, state_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [15:0]   n_q, n_n;
  logic [7:0]    n_lo_q, n_lo_n;

  logic          we_n, ready_n, busy_n, done_n, err_n, cpu_rst_n_n;
  logic [31:0]   addr_n, wdata_n;

  logic          accept, start_go, asm_valid, word_valid;
  logic [31:0]   word;
  logic [15:0]   hdr_n;

  assign accept    = byte_valid_i && byte_ready_o;
  assign start_go  = start_i && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign asm_valid = accept && (state_q == ST_DATA);
  assign hdr_n     = {byte_data_i, n_lo_q};
  assign state_o   = state_q;

  byte_word_assembler u_asm (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (start_go),
    .byte_valid (asm_valid),
    .byte_data  (byte_data_i),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next-state, counters and next output values.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    hold_n  = hold_q;
    n_n     = n_q;
    n_lo_n  = n_lo_q;
    we_n    = 1'b0;
    addr_n  = im_addr_o;
    wdata_n = im_wdata_o;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_n = ST_HDR0;
          idx_n   = '0;
          hold_n  = '0;
        end
      end
      ST_HDR0: begin
        if (accept) begin
          n_lo_n  = byte_data_i;
          state_n = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (accept) begin
          n_n   = hdr_n;
          idx_n = '0;
          if (32'(hdr_n) > 32'(IM_WORDS)) begin
            state_n = ST_ERR;
          end else if (hdr_n == 16'd0) begin
            state_n = ST_FILL;
          end else begin
            state_n = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          we_n    = 1'b1;
          addr_n  = 32'({idx_q, 2'b00});
          wdata_n = word;
          idx_n   = idx_q + 1'b1;
          if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
            // A full image leaves nothing to zero-fill.
            state_n = (32'(n_q) == 32'(IM_WORDS)) ? ST_HOLD : ST_FILL;
          end
        end
      end
      ST_FILL: begin
        // Zero words past the image so the CPU halts on the first of them.
        we_n    = 1'b1;
        addr_n  = 32'({idx_q, 2'b00});
        wdata_n = 32'd0;
        idx_n   = idx_q + 1'b1;
        if (32'(idx_q) == 32'(IM_WORDS - 1)) begin
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (32'(hold_q) == 32'(HOLD_CYCLES)) begin
          state_n = ST_DONE;
        end else begin
          hold_n = hold_q + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    ready_n     = state_n inside {ST_HDR0, ST_HDR1, ST_DATA};
    busy_n      = !(state_n inside {ST_IDLE, ST_DONE, ST_ERR});
    done_n      = (state_n == ST_DONE);
    err_n       = (state_n == ST_ERR);
    cpu_rst_n_n = (state_n == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      n_q          <= '0;
      n_lo_q       <= '0;
      byte_ready_o <= 1'b0;
      im_we_o      <= 1'b0;
      im_addr_o    <= '0;
      im_wdata_o   <= '0;
      cpu_rst_n_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_n;
      idx_q        <= idx_n;
      hold_q       <= hold_n;
      n_q          <= n_n;
      n_lo_q       <= n_lo_n;
      byte_ready_o <= ready_n;
      im_we_o      <= we_n;
      im_addr_o    <= addr_n;
      im_wdata_o   <= wdata_n;
      cpu_rst_n_o  <= cpu_rst_n_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
      err_o        <= err_n;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed load sessions, scoreboarded memory writes.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int IM_WORDS    = 32;
  localparam int HOLD_CYCLES = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready_o;
  logic          im_we_o;
  logic [31:0]   im_addr_o;
  logic [31:0]   im_wdata_o;
  logic          cpu_rst_n_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  loader_state_e state_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  prog_loader #(.IM_WORDS(IM_WORDS), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready_o),
    .im_we_o      (im_we_o),
    .im_addr_o    (im_addr_o),
    .im_wdata_o   (im_wdata_o),
    .cpu_rst_n_o  (cpu_rst_n_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .state_o      (state_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int last_we_cyc = -100;
  logic [63:0] exp_q[$];
  logic [31:0] img [IM_WORDS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe pops one expected {addr, data}.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && im_we_o) begin
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h expected=none", im_addr_o, im_wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", im_addr_o, e[63:32]);
        check("wr_data", im_wdata_o, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
    int t;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        byte_valid = 1'b0;
        @(negedge clk);
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    start      = with_start;
    t = 0;
    while (!byte_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input bit with_start);
    send_byte(w[7:0],   gaps, with_start);
    send_byte(w[15:8],  gaps, 1'b0);
    send_byte(w[23:16], gaps, 1'b0);
    send_byte(w[31:24], gaps, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",  32'(busy_o),       32'd1);
    check("start_ready", 32'(byte_ready_o), 32'd1);
    check("start_cpurst",32'(cpu_rst_n_o),  32'd0);
    check("start_done",  32'(done_o),       32'd0);
    check("start_err",   32'(err_o),        32'd0);
  endtask

  task automatic wait_done(input int exp_len, input int t0);
    int t;
    t = 0;
    while (!done_o && !err_o && t < 3000) begin
      check("rst_held", 32'(cpu_rst_n_o), 32'd0);
      @(negedge clk);
      t++;
    end
    check("done",        32'(done_o),      32'd1);
    check("done_cpurst", 32'(cpu_rst_n_o), 32'd1);
    check("done_busy",   32'(busy_o),      32'd0);
    check("hold_gap",    32'(cyc - last_we_cyc), 32'(HOLD_CYCLES + 1));
    if (exp_len > 0) check("session_len", 32'(cyc - t0), 32'(exp_len));
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Full session: expectations pushed first, then stimulus.
  task automatic load_image(input int n, input bit gaps, input int start_at);
    logic [15:0] nn;
    int t0;
    nn = 16'(n);
    for (int i = 0; i < IM_WORDS; i++)
      exp_q.push_back({32'(i * 4), (i < n) ? img[i] : 32'd0});
    pulse_start();
    t0 = cyc;
    send_byte(nn[7:0],  gaps, 1'b0);
    send_byte(nn[15:8], gaps, 1'b0);
    for (int i = 0; i < n; i++) send_word(img[i], gaps, i == start_at);
    byte_valid = 1'b0;
    wait_done(gaps ? 0 : 2 + 4 * n + (IM_WORDS - n) + HOLD_CYCLES + 1, t0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #1;
    check("rst_ready",  32'(byte_ready_o), 32'd0);
    check("rst_we",     32'(im_we_o),      32'd0);
    check("rst_addr",   im_addr_o,         32'd0);
    check("rst_wdata",  im_wdata_o,        32'd0);
    check("rst_cpurst", 32'(cpu_rst_n_o),  32'd0);
    check("rst_busy",   32'(busy_o),       32'd0);
    check("rst_done",   32'(done_o),       32'd0);
    check("rst_err",    32'(err_o),        32'd0);
    check("rst_state",  32'(state_o),      32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two-word image.
    img[0] = 32'h4C220005; img[1] = 32'h00000000;
    load_image(2, 1'b0, -1);

    // Oversized header: abort, no writes, then recover.
    pulse_start();
    send_byte(8'h21, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    check("err_level",  32'(err_o),        32'd1);
    check("err_ready",  32'(byte_ready_o), 32'd0);
    check("err_busy",   32'(busy_o),       32'd0);
    check("err_cpurst", 32'(cpu_rst_n_o),  32'd0);
    check("err_done",   32'(done_o),       32'd0);
    byte_valid = 1'b1; byte_data = 8'hAA;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    check("err_hold",        32'(err_o),       32'd1);
    check("err_cpurst_hold", 32'(cpu_rst_n_o), 32'd0);
    load_image(2, 1'b0, -1);

    // Empty image: pure zero fill.
    load_image(0, 1'b0, -1);

    // Four words, gap-free then with random valid gaps.
    img[0] = 32'h11223344; img[1] = 32'hDEADBEEF;
    img[2] = 32'h00000001; img[3] = 32'h80000000;
    load_image(4, 1'b0, -1);
    load_image(4, 1'b1, -1);

    // Reset mid-DATA after 5 data bytes (one word written, one byte stale).
    exp_q.push_back({32'h0, img[0]});
    pulse_start();
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_word(img[0], 1'b0, 1'b0);
    send_byte(8'hFF, 1'b0, 1'b0);
    byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready",  32'(byte_ready_o), 32'd0);
    check("mid_rst_we",     32'(im_we_o),      32'd0);
    check("mid_rst_addr",   im_addr_o,         32'd0);
    check("mid_rst_wdata",  im_wdata_o,        32'd0);
    check("mid_rst_cpurst", 32'(cpu_rst_n_o),  32'd0);
    check("mid_rst_busy",   32'(busy_o),       32'd0);
    check("mid_rst_state",  32'(state_o),      32'(ST_IDLE));
    check("mid_rst_q",      32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    img[0] = 32'h0BADF00D; img[1] = 32'h12345678; img[2] = 32'hCAFEBABE;
    load_image(3, 1'b0, -1);

    // start_i during DATA is ignored.
    img[0] = 32'h00A00093; img[1] = 32'hFFF00113;
    load_image(2, 1'b0, 1);

    // Restart from DONE with a full-size image overwriting everything.
    for (int i = 0; i < IM_WORDS; i++) img[i] = 32'h01010101 * 32'(i) + 32'h10000000;
    load_image(IM_WORDS, 1'b0, -1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
